blit_inner_loop: RTL and testbench
==================================

// Module: blit_inner_loop
// PURPOSE
// - Blitter inner-loop control state machine; sits directly downstream of the outer-loop controller.
// - Started by the outer loop's INLP decode. Loads the inner count on LDICNTL.
// - Sequences source-read, destination-read and destination-write memory cycles per pixel/byte.
// - Returns IQUIET to the outer loop when the pass completes, or when a collision aborts it.
// PARAMETERS
// - ICNT_W   8   inner count width; a loaded value of 0 means 2**ICNT_W iterations
// PORTS
// - MasterClock  in   1       system clock; all flops on rising edge
// - SRESET       in   1       asynchronous, active-high reset
// - CCLK         in   1       blitter cycle enable; state/counter advance only when high
// - INLP         in   1       outer loop in "run inner" state (level)
// - LDICNTL      in   1       active-low load strobe for the inner counter
// - INCNT        in   ICNT_W  inner count value from the parameter register
// - SRCEN        in   1       source read enabled for this blit
// - SRCENF       in   1       source read on first iteration only (valid when SRCEN=1)
// - DSTEN        in   1       destination read enabled
// - MEMDN        in   1       memory cycle complete (1-cycle pulse from bus sequencer)
// - COLST        in   1       collision stop request
// - SRCRD        out  1       source read cycle request
// - DSTRD        out  1       destination read cycle request
// - DSTWR        out  1       destination write cycle request
// - SUPD         out  1       1-cycle pulse: step source address
// - DUPD         out  1       1-cycle pulse: step destination address
// - INNER0       out  1       inner counter equals 1 (last iteration)
// - IQUIET       out  1       inner loop idle
// - COLLIDED     out  1       sticky: pass ended by COLST; cleared on next start
// BEHAVIOUR
// - Asynchronous SRESET sets the following immediately and at any time, including mid-pass:
//   - state=IDLE, counter=0, COLLIDED=0, IQUIET=1
//   - SRCRD/DSTRD/DSTWR/SUPD/DUPD=0
//   - the pending memory request is dropped
// - Counter: on a CCLK edge with LDICNTL=0 it loads INCNT; the load has priority over a decrement.
//   - Decrements by 1 on completion of each WRITE; wraps modulo 2**ICNT_W (0 loaded => 256 iterations).
//   - INNER0 = (counter == 1), combinational from the counter register.
// - States: IDLE, SRC, DST, WRITE. All transitions are gated by CCLK, except the MEMDN capture.
//   - MEMDN is latched into a done flag that is cleared on each state change.
// - IDLE: IQUIET=1. When CCLK & INLP & IQUIET, clear COLLIDED and set first=1, then go to:
//   - SRC if SRCEN, else DST if DSTEN, else WRITE.
// - SRC: SRCRD=1. On done & CCLK: pulse SUPD, then go to DST if DSTEN, else WRITE.
// - DST: DSTRD=1. On done & CCLK: go to WRITE.
// - WRITE: DSTWR=1. On done & CCLK: pulse DUPD, decrement the counter, clear first, then:
//   - if INNER0=1, go to IDLE;
//   - else go to SRC if SRCEN & !(SRCENF & !first), else DST if DSTEN, else WRITE.
// - IQUIET=0 from the first CCLK after the start until the CCLK that returns the FSM to IDLE.
//   - The outer loop samples IQUIET one CCLK later.
// - COLST is sampled only in DST on the same edge as done.
//   - If high: skip WRITE, go to IDLE, set COLLIDED=1; the counter is unchanged.
// - Request outputs are registered; exactly one of SRCRD/DSTRD/DSTWR is high outside IDLE.
//   - A request is held until its MEMDN is accepted.
// - MEMDN arriving in IDLE is ignored. MEMDN and CCLK in the same cycle count as done for that edge.
// - INLP dropping mid-pass does not abort the pass; the FSM completes the count.
// - LDICNTL=0 while not IQUIET is a protocol error: the counter still loads (load wins).
//   - The assertion in the bench flags this.
// STRUCTURE
// - Shared package blit_pkg:
//   - typedef enum logic [1:0] inner_state_t {IDLE, SRC, DST, WRITE}
//   - localparam ICNT_W_DEF = 8
// - Sub-module blit_inner_counter: load/decrement/zero-one detect, parameterised by ICNT_W.
// - The FSM, done-flag and request registers stay in blit_inner_loop.
// TESTING
// - Reset mid-WRITE -> all requests 0 and IQUIET=1 immediately; counter=0 after release.
// - INCNT=3, SRCEN=1, DSTEN=1 -> three SRC->DST->WRITE iterations, 3 SUPD, 3 DUPD, then IQUIET=1.
// - INCNT=0, SRCEN=DSTEN=0 -> 256 WRITE cycles, INNER0 high only during the 256th.
// - INCNT=4, SRCEN=1, SRCENF=1, DSTEN=0 -> SRC once, then 4 WRITEs; SUPD pulses once.
// - INCNT=5, DSTEN=1, COLST=1 at 2nd DST done -> no 2nd WRITE, IDLE, COLLIDED=1, counter=4.
// - MEMDN held off 10 CCLKs in SRC -> SRCRD stays high throughout; no state change; no SUPD.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared blitter definitions: inner-loop state encoding and default widths.
package blit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SRC   = 2'd1,
    DST   = 2'd2,
    WRITE = 2'd3
  } inner_state_t;

  localparam int ICNT_W_DEF = 8;

endpackage

// File: rtl/blit_inner_counter.sv
// Inner iteration counter: load, decrement (wrapping), last-iteration detect.
module blit_inner_counter #(
  parameter int ICNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              dec,
  input  logic [ICNT_W-1:0] load_val,
  output logic [ICNT_W-1:0] cnt,
  output logic              is_one
);

  // Load wins over decrement; decrement wraps so a loaded 0 gives 2**ICNT_W passes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  // Last iteration is flagged when the counter holds 1.
  always_comb is_one = (cnt == ICNT_W'(1));

endmodule

// File: rtl/blit_inner_loop.sv
// Blitter inner-loop sequencer: issues source-read, destination-read and
// destination-write requests per iteration and reports idle to the outer loop.
import blit_pkg::*;

module blit_inner_loop #(
  parameter int ICNT_W = ICNT_W_DEF
) (
  input  logic              MasterClock,
  input  logic              SRESET,
  input  logic              CCLK,
  input  logic              INLP,
  input  logic              LDICNTL,
  input  logic [ICNT_W-1:0] INCNT,
  input  logic              SRCEN,
  input  logic              SRCENF,
  input  logic              DSTEN,
  input  logic              MEMDN,
  input  logic              COLST,
  output logic              SRCRD,
  output logic              DSTRD,
  output logic              DSTWR,
  output logic              SUPD,
  output logic              DUPD,
  output logic              INNER0,
  output logic              IQUIET,
  output logic              COLLIDED
);

  inner_state_t state, state_d;
  logic         done_q;
  logic         done;
  logic         adv;
  logic         first, first_d;
  logic         supd_d, dupd_d;
  logic         cnt_dec;
  logic         cnt_load;
  logic         col_set;
  logic         start;
  logic [ICNT_W-1:0] cnt;

  // A MEMDN coinciding with the enabling CCLK counts immediately.
  assign done     = done_q | MEMDN;
  assign adv      = CCLK & done;
  assign start    = CCLK & INLP & IQUIET;
  assign cnt_load = CCLK & ~LDICNTL;

  blit_inner_counter #(.ICNT_W(ICNT_W)) u_cnt (
    .clk      (MasterClock),
    .rst      (SRESET),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (INCNT),
    .cnt      (cnt),
    .is_one   (INNER0)
  );

  // Next-state, address-step pulses and counter decrement.
  always_comb begin
    state_d = state;
    first_d = first;
    supd_d  = 1'b0;
    dupd_d  = 1'b0;
    cnt_dec = 1'b0;
    col_set = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          first_d = 1'b1;
          state_d = SRCEN ? SRC : (DSTEN ? DST : WRITE);
        end
      end
      SRC: begin
        if (adv) begin
          supd_d  = 1'b1;
          state_d = DSTEN ? DST : WRITE;
        end
      end
      DST: begin
        if (adv) begin
          if (COLST) begin
            col_set = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (adv) begin
          dupd_d  = 1'b1;
          cnt_dec = 1'b1;
          first_d = 1'b0;
          // SRCENF restricts source reads to the first iteration only.
          if (INNER0)                          state_d = IDLE;
          else if (SRCEN & ~(SRCENF & ~first_d)) state_d = SRC;
          else if (DSTEN)                      state_d = DST;
          else                                 state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, done flag, sticky collision and registered request/pulse outputs.
  always_ff @(posedge MasterClock or posedge SRESET) begin
    if (SRESET) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      first    <= 1'b0;
      COLLIDED <= 1'b0;
      IQUIET   <= 1'b1;
      SRCRD    <= 1'b0;
      DSTRD    <= 1'b0;
      DSTWR    <= 1'b0;
      SUPD     <= 1'b0;
      DUPD     <= 1'b0;
    end else begin
      state  <= state_d;
      first  <= first_d;
      // Completion is held until the state moves on; ignored while idle.
      if (state_d != state)              done_q <= 1'b0;
      else if (state != IDLE && MEMDN)   done_q <= 1'b1;
      if (start)        COLLIDED <= 1'b0;
      else if (col_set) COLLIDED <= 1'b1;
      IQUIET <= (state_d == IDLE);
      SRCRD  <= (state_d == SRC);
      DSTRD  <= (state_d == DST);
      DSTWR  <= (state_d == WRITE);
      SUPD   <= supd_d;
      DUPD   <= dupd_d;
    end
  end

endmodule

// File: tb/tb_blit_inner_loop.sv
// Directed bench for the blitter inner-loop sequencer.
module tb_blit_inner_loop;

  logic       MasterClock = 1'b0;
  logic       SRESET = 1'b1;
  logic       CCLK = 1'b1;
  logic       INLP = 1'b0;
  logic       LDICNTL = 1'b1;
  logic [7:0] INCNT = '0;
  logic       SRCEN = 1'b0;
  logic       SRCENF = 1'b0;
  logic       DSTEN = 1'b0;
  logic       MEMDN = 1'b0;
  logic       COLST = 1'b0;
  logic       SRCRD, DSTRD, DSTWR, SUPD, DUPD, INNER0, IQUIET, COLLIDED;

  int errors = 0;
  int checks = 0;
  int supd_cnt = 0;
  int dupd_cnt = 0;

  // {SRCRD,DSTRD,DSTWR,SUPD,DUPD,INNER0,IQUIET,COLLIDED}
  logic [7:0] outv;
  assign outv = {SRCRD, DSTRD, DSTWR, SUPD, DUPD, INNER0, IQUIET, COLLIDED};

  blit_inner_loop #(.ICNT_W(8)) dut (
    .MasterClock (MasterClock),
    .SRESET      (SRESET),
    .CCLK        (CCLK),
    .INLP        (INLP),
    .LDICNTL     (LDICNTL),
    .INCNT       (INCNT),
    .SRCEN       (SRCEN),
    .SRCENF      (SRCENF),
    .DSTEN       (DSTEN),
    .MEMDN       (MEMDN),
    .COLST       (COLST),
    .SRCRD       (SRCRD),
    .DSTRD       (DSTRD),
    .DSTWR       (DSTWR),
    .SUPD        (SUPD),
    .DUPD        (DUPD),
    .INNER0      (INNER0),
    .IQUIET      (IQUIET),
    .COLLIDED    (COLLIDED)
  );

  always #5 MasterClock = ~MasterClock;

  always @(posedge MasterClock) begin
    if (SUPD) supd_cnt <= supd_cnt + 1;
    if (DUPD) dupd_cnt <= dupd_cnt + 1;
  end

  // Loading the counter while a pass is running is a protocol error.
  always @(posedge MasterClock) begin
    if (!SRESET && CCLK && !LDICNTL)
      assert (IQUIET) else $error("LDICNTL asserted while inner loop busy");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge MasterClock);
    #1;
  endtask

  task automatic load_cnt(input logic [7:0] v);
    INCNT = v; LDICNTL = 1'b0;
    tick();
    LDICNTL = 1'b1;
  endtask

  task automatic start_pass();
    INLP = 1'b1;
    tick();
    INLP = 1'b0;
  endtask

  task automatic mem_ack();
    MEMDN = 1'b1;
    tick();
    MEMDN = 1'b0;
  endtask

  task automatic test_reset();
    SRESET = 1'b1;
    tick(); tick();
    checks++;
    if (outv !== 8'b0000_0010) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", outv, 8'b0000_0010);
    end
    SRESET = 1'b0;
    tick();
    checks++;
    if (dut.u_cnt.cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", dut.u_cnt.cnt);
    end
  endtask

  task automatic test_src_dst_write();
    int s0, d0;
    logic [7:0] exp;
    SRCEN = 1'b1; SRCENF = 1'b0; DSTEN = 1'b1;
    load_cnt(8'd3);
    s0 = supd_cnt; d0 = dupd_cnt;
    start_pass();
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, 1'b0, 1'b0, 1'b0, (i > 0), (i == 2), 1'b0, 1'b0};
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL sdw_src[%0d]: got %b want %b", i, outv, exp); end
      mem_ack();
      exp = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, (i == 2), 1'b0, 1'b0};
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL sdw_dst[%0d]: got %b want %b", i, outv, exp); end
      mem_ack();
      exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, (i == 2), 1'b0, 1'b0};
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL sdw_wr[%0d]: got %b want %b", i, outv, exp); end
      mem_ack();
    end
    checks++;
    if (outv !== 8'b0000_1010) begin errors++; $display("FAIL sdw_end: got %b want %b", outv, 8'b0000_1010); end
    tick();
    checks++;
    if (supd_cnt - s0 !== 3 || dupd_cnt - d0 !== 3) begin
      errors++; $display("FAIL sdw_pulses: supd=%0d dupd=%0d want 3/3", supd_cnt - s0, dupd_cnt - d0);
    end
  endtask

  task automatic test_wrap_256();
    int d0, bad;
    logic [7:0] exp;
    SRCEN = 1'b0; SRCENF = 1'b0; DSTEN = 1'b0;
    load_cnt(8'd0);
    d0 = dupd_cnt; bad = 0;
    start_pass();
    for (int i = 0; i < 256; i++) begin
      exp = {1'b0, 1'b0, 1'b1, 1'b0, (i > 0), (i == 255), 1'b0, 1'b0};
      checks++;
      if (outv !== exp) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL wrap_wr[%0d]: got %b want %b", i, outv, exp);
      end
      mem_ack();
    end
    checks++;
    if (outv !== 8'b0000_1010) begin errors++; $display("FAIL wrap_end: got %b want %b", outv, 8'b0000_1010); end
    tick();
    checks++;
    if (dupd_cnt - d0 !== 256 || dut.u_cnt.cnt !== 8'd0) begin
      errors++; $display("FAIL wrap_totals: dupd=%0d cnt=%0d want 256/0", dupd_cnt - d0, dut.u_cnt.cnt);
    end
  endtask

  task automatic test_src_first_only();
    int s0;
    logic [7:0] exp;
    SRCEN = 1'b1; SRCENF = 1'b1; DSTEN = 1'b0;
    load_cnt(8'd4);
    s0 = supd_cnt;
    start_pass();
    checks++;
    if (outv !== 8'b1000_0000) begin errors++; $display("FAIL srcf_src: got %b want %b", outv, 8'b1000_0000); end
    mem_ack();
    for (int i = 0; i < 4; i++) begin
      exp = {1'b0, 1'b0, 1'b1, (i == 0), (i > 0), (i == 3), 1'b0, 1'b0};
      checks++;
      if (outv !== exp) begin errors++; $display("FAIL srcf_wr[%0d]: got %b want %b", i, outv, exp); end
      mem_ack();
    end
    checks++;
    if (outv !== 8'b0000_1010) begin errors++; $display("FAIL srcf_end: got %b want %b", outv, 8'b0000_1010); end
    tick();
    checks++;
    if (supd_cnt - s0 !== 1) begin errors++; $display("FAIL srcf_supd: got %0d want 1", supd_cnt - s0); end
  endtask

  task automatic test_collision_and_reset();
    SRCEN = 1'b0; SRCENF = 1'b0; DSTEN = 1'b1;
    load_cnt(8'd5);
    start_pass();
    checks++;
    if (outv !== 8'b0100_0000) begin errors++; $display("FAIL col_dst1: got %b want %b", outv, 8'b0100_0000); end
    mem_ack();
    mem_ack();
    checks++;
    if (outv !== 8'b0100_1000 || dut.u_cnt.cnt !== 8'd4) begin
      errors++; $display("FAIL col_dst2: got %b cnt=%0d want %b cnt=4", outv, dut.u_cnt.cnt, 8'b0100_1000);
    end
    COLST = 1'b1;
    mem_ack();
    COLST = 1'b0;
    checks++;
    if (outv !== 8'b0000_0011 || dut.u_cnt.cnt !== 8'd4) begin
      errors++; $display("FAIL col_stop: got %b cnt=%0d want %b cnt=4", outv, dut.u_cnt.cnt, 8'b0000_0011);
    end
    // Restart clears the sticky flag; then reset lands in the middle of WRITE.
    start_pass();
    checks++;
    if (outv !== 8'b0100_0000) begin errors++; $display("FAIL col_restart: got %b want %b", outv, 8'b0100_0000); end
    mem_ack();
    checks++;
    if (outv !== 8'b0010_0000) begin errors++; $display("FAIL rst_pre: got %b want %b", outv, 8'b0010_0000); end
    #2 SRESET = 1'b1;
    #1;
    checks++;
    if (outv !== 8'b0000_0010 || dut.u_cnt.cnt !== 8'd0) begin
      errors++; $display("FAIL rst_async: got %b cnt=%0d want %b cnt=0", outv, dut.u_cnt.cnt, 8'b0000_0010);
    end
    tick();
    SRESET = 1'b0;
    tick(); tick();
    checks++;
    if (outv !== 8'b0000_0010 || dut.u_cnt.cnt !== 8'd0) begin
      errors++; $display("FAIL rst_release: got %b cnt=%0d want %b cnt=0", outv, dut.u_cnt.cnt, 8'b0000_0010);
    end
  endtask

  task automatic test_mem_holdoff();
    int s0;
    SRCEN = 1'b1; SRCENF = 1'b0; DSTEN = 1'b0;
    load_cnt(8'd1);
    // Completion seen while idle must not carry into the next pass.
    mem_ack();
    s0 = supd_cnt;
    start_pass();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (outv !== 8'b1000_0100) begin errors++; $display("FAIL hold_src[%0d]: got %b want %b", i, outv, 8'b1000_0100); end
      tick();
    end
    // MEMDN without CCLK is remembered but must not advance.
    CCLK = 1'b0; MEMDN = 1'b1;
    tick();
    MEMDN = 1'b0;
    checks++;
    if (outv !== 8'b1000_0100 || supd_cnt != s0) begin
      errors++; $display("FAIL hold_nocclk: got %b supd=%0d want %b supd=0", outv, supd_cnt - s0, 8'b1000_0100);
    end
    CCLK = 1'b1;
    tick();
    checks++;
    if (outv !== 8'b0011_0100) begin errors++; $display("FAIL hold_adv: got %b want %b", outv, 8'b0011_0100); end
    mem_ack();
    checks++;
    if (outv !== 8'b0000_1010) begin errors++; $display("FAIL hold_end: got %b want %b", outv, 8'b0000_1010); end
  endtask

  initial begin
    test_reset();
    test_src_dst_write();
    test_wrap_256();
    test_src_first_only();
    test_collision_and_reset();
    test_mem_holdoff();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
